axis_byte_serializer: RTL and testbench
=======================================

AXIS_BYTE_SERIALIZER -- requirements
Module: axis_byte_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving the width of the output spike vector received from the processor's AXIS master port (1..64).
REQ-002 SHALL derive localparam NUM_BYTES = ceil(DATA_WIDTH/8); it is not overridable.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 arstn  input  1  reset, asynchronous, active-low.
REQ-005 s_axis_tdata  input  DATA_WIDTH  output spike vector from the upstream processor.
REQ-006 s_axis_tvalid  input  1  upstream word valid.
REQ-007 s_axis_tready  output  1  block can accept a word this cycle.
REQ-008 m_axis_tdata  output  8  serialized byte toward the host link.
REQ-009 m_axis_tvalid  output  1  byte valid.
REQ-010 m_axis_tready  input  1  downstream byte accepted.
REQ-011 m_axis_tlast  output  1  final byte of a word; present only when AXIS_TLAST_EN is defined.

Function
REQ-012 SHALL implement two states: IDLE (no word held) and SEND (word held, byte index idx in 0..NUM_BYTES-1).
REQ-013 Word accept: s_axis_tvalid && s_axis_tready at a rising edge.
REQ-014 s_axis_tready SHALL be 1 in IDLE, and in SEND only when idx == NUM_BYTES-1 && m_axis_tvalid && m_axis_tready; otherwise 0. The combinational path from m_axis_tready to s_axis_tready is intentional.
REQ-015 On accept, SHALL zero-extend the word to 8*NUM_BYTES bits, register it, set idx=0, enter SEND, and present the most significant byte with m_axis_tvalid=1 on the following cycle (latency 1 cycle).
REQ-016 Byte order SHALL be most significant byte first; padding zeros occupy the upper bits of byte 0.
REQ-017 In SEND, m_axis_tvalid SHALL be 1; m_axis_tdata SHALL hold stable while m_axis_tready=0.
REQ-018 Byte handshake with idx < NUM_BYTES-1: idx increments and the next byte appears the following cycle.
REQ-019 Byte handshake with idx == NUM_BYTES-1: if a new word is accepted in the same cycle, reload it with idx=0 and stay in SEND (no bubble); otherwise return to IDLE with m_axis_tvalid=0.
REQ-020 In IDLE, m_axis_tvalid SHALL be 0 and m_axis_tdata SHALL be 0.
REQ-021 When NUM_BYTES==1, every accepted word SHALL produce exactly one byte, and back-to-back throughput SHALL be one word per cycle.
REQ-022 The block SHALL never drop, duplicate or reorder bytes, and words SHALL be emitted in acceptance order.

Reset
REQ-023 While arstn=0: state=IDLE, idx=0, holding register=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0.
REQ-024 Reset asserted mid-word SHALL discard the remaining bytes; after release the block is in IDLE with s_axis_tready=1 on the first cycle.

Configuration
REQ-025 Macro AXIS_TLAST_EN defined: m_axis_tlast port exists and is 1 exactly when m_axis_tvalid=1 && idx==NUM_BYTES-1, otherwise 0.
REQ-026 Macro AXIS_TLAST_EN undefined: no m_axis_tlast port and no tlast logic; all other behaviour identical.

Verification
REQ-027 DATA_WIDTH=16, m_axis_tready=1, word 0xA55A -> bytes 0xA5, 0x5A on consecutive cycles starting 1 cycle after accept; s_axis_tready low for exactly 1 cycle.
REQ-028 DATA_WIDTH=12, word 0xFFF -> bytes 0x0F, 0xFF; with AXIS_TLAST_EN, tlast=0 on the first byte and 1 on the second.
REQ-029 DATA_WIDTH=16, s_axis_tvalid held high with words 0x1234, 0x5678 -> byte stream 12 34 56 78 with no idle cycle between words.
REQ-030 DATA_WIDTH=16, m_axis_tready toggling 1,0,0,1,... on word 0xBEEF -> 0xBE held stable while stalled; exactly 2 bytes, no duplicates; s_axis_tready=0 until the final byte handshake.
REQ-031 DATA_WIDTH=24, arstn pulsed low after the first byte of 0x123456 -> all outputs 0 during reset; next word 0x000001 -> bytes 00 00 01 only.
REQ-032 DATA_WIDTH=8, 50 back-to-back words 0..49 with m_axis_tready=1 -> 50 bytes 0..49 at one per cycle; s_axis_tready stays 1 throughout.

Source files
------------

// File: rtl/axis_byte_serializer.sv
// -----------------------------------------------------------------------------
// axis_byte_serializer
//
// Purpose:
//   Takes one DATA_WIDTH-bit spike vector per AXI-Stream transfer from the
//   processor and emits it as a sequence of bytes toward the host link, most
//   significant byte first. The word is zero-extended to a whole number of
//   bytes; the padding zeros land in the upper bits of the first byte.
//   A new word can be accepted in the same cycle as the final byte handshake,
//   so back-to-back words stream with no idle cycle between them.
//
// Parameters:
//   DATA_WIDTH     width of the incoming spike vector (1..64), default 16
//
// Ports:
//   clk            single clock, rising-edge active
//   arstn          asynchronous reset, active low
//   s_axis_tdata   [DATA_WIDTH-1:0] incoming word
//   s_axis_tvalid  incoming word valid
//   s_axis_tready  block can accept a word this cycle
//   m_axis_tdata   [7:0] outgoing byte
//   m_axis_tvalid  outgoing byte valid
//   m_axis_tready  downstream accepts the byte
//   m_axis_tlast   final byte of a word (only with AXIS_TLAST_EN)
//
// Configuration:
//   AXIS_TLAST_EN  when defined, adds the m_axis_tlast output and its logic.
// -----------------------------------------------------------------------------
module axis_byte_serializer #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  arstn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [7:0]            m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready
`ifdef AXIS_TLAST_EN
   ,
   output logic                  m_axis_tlast
`endif
);

   localparam int NUM_BYTES = (DATA_WIDTH + 7) / 8;
   localparam int HOLD_W    = 8 * NUM_BYTES;
   // A single-byte word still needs a 1-bit index so the vector is legal.
   localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   logic [0:0]        state;
   logic [IDX_W-1:0]  idx;
   // Holds the remaining bytes of the current word, next byte in the top 8 bits.
   logic [HOLD_W-1:0] hold;

   logic byte_hs;
   logic last_byte;
   logic word_acc;

   assign m_axis_tvalid = (state == ST_SEND);
   assign byte_hs       = m_axis_tvalid && m_axis_tready;
   assign last_byte     = (idx == LAST_IDX);

   // Ready in IDLE, or while the final byte is being handed off so the next
   // word reloads without a bubble. The path from m_axis_tready is
   // deliberately combinational. Gating with arstn keeps ready low while the
   // block is held in reset and lets it rise on the first cycle after release.
   assign s_axis_tready = arstn && ((state == ST_IDLE) || (last_byte && byte_hs));
   assign word_acc      = s_axis_tvalid && s_axis_tready;

   // IDLE forces the byte output to zero regardless of the holding register.
   assign m_axis_tdata  = (state == ST_SEND) ? hold[HOLD_W-1 -: 8] : 8'h00;

`ifdef AXIS_TLAST_EN
   assign m_axis_tlast  = m_axis_tvalid && last_byte;
`endif

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, whatever the block order.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state <= ST_IDLE;
         idx   <= '0;
         // NOTE: the holding register is reset too; it is a plain register,
         // not a memory, and a known value keeps the byte output clean.
         hold  <= '0;
      end else if (word_acc) begin
         // Covers both the IDLE accept and the reload on the final byte.
         state <= ST_SEND;
         idx   <= '0;
         hold  <= HOLD_W'(s_axis_tdata);
      end else if (byte_hs) begin
         if (last_byte) begin
            state <= ST_IDLE;
            idx   <= '0;
            hold  <= '0;
         end else begin
            idx   <= idx + IDX_W'(1);
            hold  <= hold << 8;
         end
      end
   end

endmodule

// File: tb/tb_axis_byte_serializer.sv
// -----------------------------------------------------------------------------
// tb_axis_byte_serializer
//
// Four serializer instances (DATA_WIDTH 16, 12, 24, 8) share clock and reset.
// A per-instance byte queue models the expected output stream: every accepted
// word pushes its bytes MSB first, every byte handshake pops one. The queue
// alone defines what valid, data, ready and last must be on each cycle.
// Directed scenarios add literal expectations on top of that model.
// -----------------------------------------------------------------------------
module tb_axis_byte_serializer;

   function automatic int dw_of(input int i);
      case (i)
         0:       return 16;
         1:       return 12;
         2:       return 24;
         default: return 8;
      endcase
   endfunction

   logic             clk = 1'b0;
   logic             arstn;
   logic [3:0][63:0] s_data;
   logic [3:0]       s_valid;
   logic [3:0]       m_ready;
   wire  [3:0]       s_ready;
   wire  [3:0]       m_valid;
   wire  [3:0][7:0]  m_data;
`ifdef AXIS_TLAST_EN
   wire  [3:0]       m_last;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] exp_q [4][$];
   logic [7:0] got_q [4][$];
   int         got_c [4][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int DW = dw_of(g);
      axis_byte_serializer #(.DATA_WIDTH(DW)) u_dut (
         .clk           (clk),
         .arstn         (arstn),
         .s_axis_tdata  (s_data[g][DW-1:0]),
         .s_axis_tvalid (s_valid[g]),
         .s_axis_tready (s_ready[g]),
         .m_axis_tdata  (m_data[g]),
         .m_axis_tvalid (m_valid[g]),
         .m_axis_tready (m_ready[g])
`ifdef AXIS_TLAST_EN
         ,
         .m_axis_tlast  (m_last[g])
`endif
      );
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model compare: outputs are stable mid-cycle, and the handshakes seen here
   // are exactly the ones the next rising edge will commit.
   always @(negedge clk) begin
      for (int d = 0; d < 4; d++) begin
         int sz;
         int nb;
         logic [63:0] w;
         sz = exp_q[d].size();
         nb = (dw_of(d) + 7) / 8;
         if (!arstn) begin
            check($sformatf("d%0d_rst_tvalid", d), m_valid[d], 0);
            check($sformatf("d%0d_rst_tdata", d), m_data[d], 0);
            check($sformatf("d%0d_rst_sready", d), s_ready[d], 0);
`ifdef AXIS_TLAST_EN
            check($sformatf("d%0d_rst_tlast", d), m_last[d], 0);
`endif
            exp_q[d].delete();
         end else begin
            check($sformatf("d%0d_tvalid", d), m_valid[d], (sz != 0));
            check($sformatf("d%0d_tdata", d), m_data[d], (sz != 0) ? exp_q[d][0] : 8'h00);
            check($sformatf("d%0d_sready", d), s_ready[d], (sz == 0) || (sz == 1 && m_ready[d]));
`ifdef AXIS_TLAST_EN
            check($sformatf("d%0d_tlast", d), m_last[d], (sz == 1));
`endif
            if (m_valid[d] && m_ready[d]) begin
               got_q[d].push_back(m_data[d]);
               got_c[d].push_back(cyc);
               if (sz != 0) void'(exp_q[d].pop_front());
            end
            if (s_valid[d] && s_ready[d]) begin
               w = s_data[d] & ((64'd1 << dw_of(d)) - 64'd1);
               for (int k = nb - 1; k >= 0; k--)
                  exp_q[d].push_back(8'((w >> (8 * k)) & 64'hFF));
            end
         end
      end
   end

   task automatic clear_log(input int d);
      got_q[d].delete();
      got_c[d].delete();
   endtask

   // Present a word and hold it until accepted (bounded); returns 1 ns after
   // the accepting edge with s_tvalid still high.
   task automatic offer(input int d, input logic [63:0] word);
      bit ok;
      ok = 1'b0;
      s_valid[d] = 1'b1;
      s_data[d]  = word;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         if (s_ready[d]) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      check($sformatf("d%0d_accept_in_time", d), ok, 1);
   endtask

   task automatic wait_idle(input int d);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         if (!m_valid[d] && exp_q[d].size() == 0) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      check($sformatf("d%0d_idle_in_time", d), ok, 1);
   endtask

   // Compare the logged byte stream against n literal bytes, first byte in
   // the most significant position of exp.
   task automatic check_bytes(input int d, input int n, input logic [31:0] exp);
      check($sformatf("d%0d_byte_count", d), got_q[d].size(), n);
      for (int i = 0; i < n && i < got_q[d].size(); i++)
         check($sformatf("d%0d_byte%0d", d, i), got_q[d][i], 8'(exp >> (8 * (n - 1 - i))));
   endtask

   initial begin
      int low;
      logic [5:0] pat;

      arstn   = 1'b0;
      s_valid = '0;
      s_data  = '0;
      m_ready = '1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_sready_all", s_ready, 4'b0000);
      check("rst_tvalid_all", m_valid, 4'b0000);
      check("rst_tdata_all", m_data, 32'h0);
      @(posedge clk);
      #1;
      arstn = 1'b1;
      @(negedge clk);
      check("post_rst_sready_all", s_ready, 4'b1111);
      @(posedge clk);
      #1;

      // 16-bit word 0xA55A, sink always ready.
      clear_log(0);
      s_valid[0] = 1'b1;
      s_data[0]  = 64'hA55A;
      @(negedge clk);
      check("t1_accept_ready", s_ready[0], 1);
      @(posedge clk);
      #1;
      s_valid[0] = 1'b0;
      @(negedge clk);
      check("t1_b0_valid", m_valid[0], 1);
      check("t1_b0_data", m_data[0], 8'hA5);
      check("t1_b0_sready", s_ready[0], 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("t1_b1_data", m_data[0], 8'h5A);
      check("t1_b1_sready", s_ready[0], 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("t1_idle_valid", m_valid[0], 0);
      check("t1_idle_data", m_data[0], 8'h00);
      @(posedge clk);
      #1;
      check_bytes(0, 2, 32'hA55A);

      // 12-bit word 0xFFF: padding lands in byte 0.
      clear_log(1);
      s_valid[1] = 1'b1;
      s_data[1]  = 64'hFFF;
      @(negedge clk);
      @(posedge clk);
      #1;
      s_valid[1] = 1'b0;
      @(negedge clk);
      check("t2_b0_data", m_data[1], 8'h0F);
`ifdef AXIS_TLAST_EN
      check("t2_b0_tlast", m_last[1], 0);
`endif
      @(posedge clk);
      #1;
      @(negedge clk);
      check("t2_b1_data", m_data[1], 8'hFF);
`ifdef AXIS_TLAST_EN
      check("t2_b1_tlast", m_last[1], 1);
`endif
      @(posedge clk);
      #1;
      wait_idle(1);
      check_bytes(1, 2, 32'h0FFF);

      // Back-to-back words with tvalid held high: no bubble.
      clear_log(0);
      offer(0, 64'h1234);
      offer(0, 64'h5678);
      s_valid[0] = 1'b0;
      wait_idle(0);
      check_bytes(0, 4, 32'h12345678);
      check("t3_span", (got_c[0].size() == 4) ? got_c[0][3] - got_c[0][0] : -1, 3);

      // Stalling sink: ready pattern 0,0,1,0,0,1 after the accept.
      clear_log(0);
      offer(0, 64'hBEEF);
      s_valid[0] = 1'b0;
      pat = 6'b100100;
      low = 0;
      for (int c = 1; c <= 6; c++) begin
         m_ready[0] = pat[c-1];
         @(negedge clk);
         if (!s_ready[0]) low++;
         check($sformatf("t4_c%0d_data", c), m_data[0], (c <= 3) ? 8'hBE : 8'hEF);
         @(posedge clk);
         #1;
      end
      m_ready[0] = 1'b1;
      wait_idle(0);
      check("t4_sready_low_cycles", low, 5);
      check_bytes(0, 2, 32'hBEEF);
      check("t4_span", (got_c[0].size() == 2) ? got_c[0][1] - got_c[0][0] : -1, 3);

      // 24-bit word interrupted by reset after its first byte.
      clear_log(2);
      offer(2, 64'h123456);
      s_valid[2] = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
      arstn = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("t5_rst_tvalid", m_valid[2], 0);
         check("t5_rst_tdata", m_data[2], 8'h00);
         check("t5_rst_sready", s_ready, 4'b0000);
         @(posedge clk);
         #1;
      end
      arstn = 1'b1;
      @(negedge clk);
      check("t5_release_sready", s_ready[2], 1);
      @(posedge clk);
      #1;
      offer(2, 64'h000001);
      s_valid[2] = 1'b0;
      wait_idle(2);
      check_bytes(2, 4, 32'h12000001);

      // 8-bit words 0..49 streamed one per cycle.
      clear_log(3);
      low = 0;
      for (int i = 0; i < 50; i++) begin
         s_valid[3] = 1'b1;
         s_data[3]  = 64'(i);
         @(negedge clk);
         if (!s_ready[3]) low++;
         @(posedge clk);
         #1;
      end
      s_valid[3] = 1'b0;
      wait_idle(3);
      check("t6_sready_low_cycles", low, 0);
      check("t6_byte_count", got_q[3].size(), 50);
      for (int i = 0; i < 50 && i < got_q[3].size(); i++)
         check($sformatf("t6_byte%0d", i), got_q[3][i], 8'(i));
      check("t6_span", (got_c[3].size() == 50) ? got_c[3][49] - got_c[3][0] : -1, 49);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog expired");
   end

endmodule
